// File: rtl/xor_pkg.sv
// Shared constants and state encoding for the serial XOR cipher sequencer.
package xor_pkg;

  localparam int KEY_BITS_DEF = 32;
  localparam int MSG_BITS_DEF = 512;
  localparam int TIMEOUT_DEF  = 1023;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_MSG = 3'd2,
    ST_ENCRYPT  = 3'd3,
    ST_STREAM   = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_e;

endpackage

// File: rtl/xor_seq_watchdog.sv
// Loadable down-counter that saturates at zero; expired_o flags the zero count.
module xor_seq_watchdog #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/xor_cipher_seq.sv
// Session sequencer: steers serial bits into key then message paths,
// triggers encryption and supervises the output stream under a watchdog.
module xor_cipher_seq
  import xor_pkg::*;
#(
  parameter  int KEY_BITS = KEY_BITS_DEF,
  parameter  int MSG_BITS = MSG_BITS_DEF,
  parameter  int TIMEOUT  = TIMEOUT_DEF,
  localparam int CW_K     = $clog2(KEY_BITS + 1),
  localparam int CW_M     = $clog2(MSG_BITS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            start,
  input  logic            abort,
  input  logic            bit_in,
  input  logic            bit_valid,
  output logic            load_key,
  output logic            load_msg,
  output logic            bit_out,
  output logic            encrypt_go,
  input  logic            encrypt_done,
  input  logic            ser_start,
  input  logic            ser_end,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2:0]      state,
  output logic [CW_K-1:0] key_cnt,
  output logic [CW_M-1:0] msg_cnt
);

  localparam int CW_W = $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic [CW_K-1:0] key_cnt_q;
  logic [CW_M-1:0] msg_cnt_q;
  logic            load_key_q, load_msg_q, bit_out_q, go_q, done_q, err_q, busy_q;
  logic            seen_start_q;

  logic            wd_load, wd_dec, wd_expired;
  logic [CW_W-1:0] wd_val;
  logic            msg_last;

  assign msg_last = bit_valid && (msg_cnt_q == CW_M'(MSG_BITS - 1));

  // Loaded with TIMEOUT-1 on ENCRYPT entry so it reads zero on the TIMEOUT-th cycle.
  always_comb begin
    wd_load = 1'b0;
    wd_val  = '0;
    wd_dec  = 1'b0;
    if (ena) begin
      if (state_q == ST_IDLE) begin
        wd_load = 1'b1;
      end else if (state_q == ST_LOAD_MSG && msg_last && !abort) begin
        wd_load = 1'b1;
        wd_val  = CW_W'(TIMEOUT - 1);
      end else if (state_q == ST_ENCRYPT || state_q == ST_STREAM) begin
        wd_dec = 1'b1;
      end
    end
  end

  xor_seq_watchdog #(.W(CW_W)) u_wd (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wd_load),
    .load_val_i (wd_val),
    .dec_i      (wd_dec),
    .expired_o  (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      key_cnt_q    <= '0;
      msg_cnt_q    <= '0;
      load_key_q   <= 1'b0;
      load_msg_q   <= 1'b0;
      bit_out_q    <= 1'b0;
      go_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      seen_start_q <= 1'b0;
    end else begin
      load_key_q <= 1'b0;
      load_msg_q <= 1'b0;
      go_q       <= 1'b0;
      done_q     <= 1'b0;
      if (ena) begin
        if (abort) begin
          state_q      <= ST_IDLE;
          key_cnt_q    <= '0;
          msg_cnt_q    <= '0;
          err_q        <= 1'b0;
          busy_q       <= 1'b0;
          seen_start_q <= 1'b0;
        end else begin
          unique case (state_q)
            ST_IDLE, ST_ERR: begin
              if (start) begin
                state_q   <= ST_LOAD_KEY;
                key_cnt_q <= '0;
                msg_cnt_q <= '0;
                err_q     <= 1'b0;
                busy_q    <= 1'b1;
              end
            end
            ST_LOAD_KEY: begin
              if (bit_valid) begin
                load_key_q <= 1'b1;
                bit_out_q  <= bit_in;
                if (key_cnt_q < CW_K'(KEY_BITS)) key_cnt_q <= key_cnt_q + 1'b1;
                if (key_cnt_q == CW_K'(KEY_BITS - 1)) state_q <= ST_LOAD_MSG;
              end
            end
            ST_LOAD_MSG: begin
              if (bit_valid) begin
                load_msg_q <= 1'b1;
                bit_out_q  <= bit_in;
                if (msg_cnt_q < CW_M'(MSG_BITS)) msg_cnt_q <= msg_cnt_q + 1'b1;
                if (msg_last) begin
                  state_q      <= ST_ENCRYPT;
                  go_q         <= 1'b1;
                  seen_start_q <= 1'b0;
                end
              end
            end
            ST_ENCRYPT: begin
              if (wd_expired) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
              end else if (encrypt_done) begin
                state_q <= ST_STREAM;
              end
            end
            ST_STREAM: begin
              if (wd_expired) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                if (ser_start) seen_start_q <= 1'b1;
                if (ser_end && seen_start_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end
              end
            end
            ST_DONE: begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
            default: begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign load_key   = load_key_q;
  assign load_msg   = load_msg_q;
  assign bit_out    = bit_out_q;
  assign encrypt_go = go_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign state      = state_q;
  assign key_cnt    = key_cnt_q;
  assign msg_cnt    = msg_cnt_q;

endmodule

// File: tb/tb_xor_cipher_seq.sv
// Directed bench for xor_cipher_seq: vector table for early-session control, then full sessions.
module tb_xor_cipher_seq;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, abort, bit_in, bit_valid;
  logic        encrypt_done, ser_start, ser_end;
  logic        load_key, load_msg, bit_out, encrypt_go, busy, done, err;
  logic [2:0]  state;
  logic [5:0]  key_cnt;
  logic [9:0]  msg_cnt;

  int n_vec = 0;
  int n_bad = 0;

  int lk_cnt = 0, lm_cnt = 0, go_cnt = 0, done_cnt = 0;
  logic [31:0] key_sh = '0;

  always #5 clk = ~clk;

  xor_cipher_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .start        (start),
    .abort        (abort),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .load_key     (load_key),
    .load_msg     (load_msg),
    .bit_out      (bit_out),
    .encrypt_go   (encrypt_go),
    .encrypt_done (encrypt_done),
    .ser_start    (ser_start),
    .ser_end      (ser_end),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .state        (state),
    .key_cnt      (key_cnt),
    .msg_cnt      (msg_cnt)
  );

  always @(negedge clk) begin
    if (load_key) begin
      lk_cnt = lk_cnt + 1;
      key_sh = {key_sh[30:0], bit_out};
    end
    if (load_msg)   lm_cnt   = lm_cnt + 1;
    if (encrypt_go) go_cnt   = go_cnt + 1;
    if (done)       done_cnt = done_cnt + 1;
  end

  typedef struct {
    logic       ena, start, abort, bv, bi;
    logic [2:0] e_state;
    logic [5:0] e_key;
    logic       e_lk, e_bo, e_busy;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic load_session(input int nmsg);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 32; i++) send_bit(i[0]);
    for (int i = 0; i < nmsg; i++) send_bit(i[1]);
  endtask

  initial begin
    int lk0, lm0, go0, d0;
    logic [31:0] key;
    key = 32'hA5A5A5A5;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    encrypt_done = 1'b0; ser_start = 1'b0; ser_end = 1'b0;
    repeat (2) step();
    chk("reset_outs", {29'd0, state}, 32'd0);
    chk("reset_flags", {busy, done, err, load_key, load_msg, bit_out, encrypt_go, key_cnt, msg_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    //          ena start abort bv bi  state key lk bo busy
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 6'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 6'd1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 6'd1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 6'd2, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 6'd2, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 6'd2, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 6'd3, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 6'd3, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 6'd0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 6'd1, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      ena = tbl[i].ena; start = tbl[i].start; abort = tbl[i].abort;
      bit_valid = tbl[i].bv; bit_in = tbl[i].bi;
      step();
      chk($sformatf("vec%0d", i), {20'd0, state, key_cnt, load_key, bit_out, busy},
          {20'd0, tbl[i].e_state, tbl[i].e_key, tbl[i].e_lk, tbl[i].e_bo, tbl[i].e_busy});
    end
    ena = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;

    // Nominal session with gapped key bits and an ena freeze mid-key
    lk0 = lk_cnt; lm0 = lm_cnt; go0 = go_cnt; d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send_bit(key[31-i]);
      repeat ($urandom_range(0, 2)) step();
      if (i == 15) begin
        ena = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
          step();
          chk("ena_freeze", {state, key_cnt, load_key}, {3'd1, 6'd16, 1'b0});
        end
        ena = 1'b1; bit_valid = 1'b0;
      end
    end
    chk("key_loads", lk_cnt - lk0, 32);
    chk("key_bits", key_sh, 32'hA5A5A5A5);
    chk("key_state", {state, key_cnt}, {3'd2, 6'd32});
    for (int i = 0; i < 512; i++) begin
      start = (i == 100);
      send_bit(i[0] ^ i[3]);
      start = 1'b0;
      if (i == 100) chk("start_in_msg", {state, msg_cnt}, {3'd2, 10'd101});
    end
    chk("go_entry", {state, encrypt_go, msg_cnt}, {3'd3, 1'b1, 10'd512});
    repeat (2) step();
    encrypt_done = 1'b1; step(); encrypt_done = 1'b0;
    chk("to_stream", {29'd0, state}, 32'd4);
    ser_end = 1'b1; step(); ser_end = 1'b0;
    chk("early_end", {29'd0, state}, 32'd4);
    ser_start = 1'b1; step(); ser_start = 1'b0;
    repeat (519) step();
    chk("stream_wait", {29'd0, state}, 32'd4);
    ser_end = 1'b1; step(); ser_end = 1'b0;
    chk("done_pulse", {state, done, busy}, {3'd5, 1'b1, 1'b1});
    step();
    chk("back_idle", {state, done, busy, key_cnt, msg_cnt}, {3'd0, 1'b0, 1'b0, 6'd32, 10'd512});
    chk("msg_loads", lm_cnt - lm0, 512);
    chk("go_count", go_cnt - go0, 1);
    chk("done_count", done_cnt - d0, 1);

    // Watchdog expiry while encrypt_done is withheld
    load_session(512);
    chk("to_encrypt", {29'd0, state}, 32'd3);
    repeat (TIMEOUT - 1) step();
    chk("pre_timeout", {state, err}, {3'd3, 1'b0});
    step();
    chk("timeout", {state, err, busy}, {3'd6, 1'b1, 1'b0});
    step();
    chk("err_sticky", {state, err}, {3'd6, 1'b1});
    start = 1'b1; step(); start = 1'b0;
    chk("err_restart", {state, err, busy, key_cnt, msg_cnt}, {3'd1, 1'b0, 1'b1, 6'd0, 10'd0});

    // Abort with msg_cnt at 200
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    for (int i = 0; i < 200; i++) send_bit(i[2]);
    chk("msg200", {state, msg_cnt}, {3'd2, 10'd200});
    abort = 1'b1; bit_valid = 1'b1; step(); abort = 1'b0; bit_valid = 1'b0;
    chk("abort", {state, load_msg, busy, key_cnt, msg_cnt}, {3'd0, 1'b0, 1'b0, 6'd0, 10'd0});
    step();
    chk("abort_nodone", done_cnt - d0, 0);

    // Async reset while streaming
    load_session(512);
    encrypt_done = 1'b1; step(); encrypt_done = 1'b0;
    ser_start = 1'b1; step(); ser_start = 1'b0;
    chk("pre_rst_stream", {29'd0, state}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {state, busy, done, err, load_key, load_msg, bit_out, encrypt_go, key_cnt, msg_cnt},
        32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst", {29'd0, state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/xor_cipher_seq.md
Name: xor_cipher_seq

Overview:
Top-level sequencer for the serial XOR cipher datapath: key deserializer, message deserializer, key assembler, XOR encryptor and output serializer.
- Accepts a host start pulse and a strobed serial bit stream.
- Steers exactly KEY_BITS bits into the key path, then MSG_BITS bits into the message path, fires encryption, and supervises the output stream to completion.
- Reports busy/done/error, enforces a watchdog timeout, and supports abort at any point.

Parameters:
KEY_BITS, 32, key length in bits loaded per session
MSG_BITS, 512, message length in bits loaded per session
TIMEOUT, 1023, max cycles allowed in ENCRYPT or STREAM before error
CW_K, $clog2(KEY_BITS+1), key counter width (derived, localparam)
CW_M, $clog2(MSG_BITS+1), message counter width (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state and counters
start  in  1  one-cycle request to begin a session (honoured only in IDLE)
abort  in  1  one-cycle request to cancel the session from any state
bit_in  in  1  serial data bit from host
bit_valid  in  1  bit_in qualifier; one bit consumed per cycle high
load_key  out  1  key deserializer load enable
load_msg  out  1  message deserializer load enable
bit_out  out  1  registered copy of bit_in fed to both deserializers
encrypt_go  out  1  one-cycle encryption trigger
encrypt_done  in  1  encryptor completion flag (level or pulse)
ser_start  in  1  serializer stream-start flag
ser_end  in  1  serializer stream-end flag
busy  out  1  high in every state except IDLE and ERR
done  out  1  one-cycle pulse on session completion
err  out  1  sticky timeout flag
state  out  3  encoded FSM state for debug
key_cnt  out  CW_K  key bits accepted this session
msg_cnt  out  CW_M  message bits accepted this session

Behaviour:
- Reset: state=IDLE; all outputs and counters 0; watchdog 0.
- All outputs are registered; load_key, load_msg and bit_out are aligned to the same cycle.
- ena=0: no state, counter or watchdog change. Bits presented are dropped. encrypt_go and done are forced 0.
- States: IDLE(0), LOAD_KEY(1), LOAD_MSG(2), ENCRYPT(3), STREAM(4), DONE(5), ERR(6).
- IDLE: start -> LOAD_KEY next cycle. Clears key_cnt, msg_cnt and watchdog.
- LOAD_KEY: each bit_valid increments key_cnt and asserts load_key with bit_out=bit_in on the following cycle. On the valid that makes key_cnt==KEY_BITS -> LOAD_MSG. Extra bits in that same cycle are impossible (one per cycle).
- LOAD_MSG: same rule with msg_cnt/load_msg. When msg_cnt reaches MSG_BITS -> ENCRYPT, and encrypt_go pulses on the entry cycle.
- ENCRYPT: waits for encrypt_done=1 -> STREAM.
- STREAM: the ser_start rise is recorded. ser_end=1 after ser_start has been seen -> DONE. ser_end without a prior ser_start is ignored.
- Watchdog: counts cycles in ENCRYPT and STREAM combined and resets on entry to ENCRYPT. Reaching TIMEOUT -> ERR.
- DONE: done=1 for exactly one cycle -> IDLE. Counters hold their final values until the next start.
- ERR: err=1 and busy=0. Stays in ERR until start (-> LOAD_KEY, err cleared) or abort (-> IDLE, err cleared).
- abort: any state -> IDLE next cycle; counters cleared, load enables dropped, no done pulse. abort and start in the same cycle: abort wins.
- start while busy: ignored, no effect.
- bit_valid outside LOAD_KEY/LOAD_MSG: ignored, counters unchanged.
- Counters saturate at KEY_BITS/MSG_BITS; no wrap.

Decomposition:
- Shared package xor_pkg: state enum encodings, default KEY_BITS/MSG_BITS/TIMEOUT constants.
- One natural sub-module: xor_seq_watchdog (loadable down-counter with expire flag), reused later for host-link timeouts.

Test Plan:
- Nominal session: start, 32 key bits of 0xA5A5A5A5, 512 message bits, encrypt_done 3 cycles after encrypt_go, ser_start then ser_end 520 cycles later -> key_cnt=32, msg_cnt=512, exactly one encrypt_go and one done pulse, state back to 0.
- Gapped bits: bit_valid toggled with random idle cycles and ena low for 10 cycles mid-key -> load_key count exactly 32, no bit lost or duplicated, state frozen while ena=0.
- Timeout: withhold encrypt_done -> err=1 at cycle TIMEOUT after ENCRYPT entry, busy=0, state=6; then start -> err=0, state=1.
- Abort mid-message at msg_cnt=200 -> state=0 next cycle, counters 0, load_msg=0, no done. Same-cycle start+abort in IDLE -> stays IDLE.
- ser_end before ser_start in STREAM -> ignored. A later proper start/end pair -> done. start pulses during LOAD_MSG -> no effect.
- Async reset asserted mid-STREAM -> all outputs 0 immediately, without waiting for a clock edge.
